// File: rtl/spi_msg_pkg.sv
// Shared constants, encodings and helpers for the spi_msg master.
package spi_msg_pkg;

    // Header opcodes (upper bits of the first MOSI byte)
    localparam logic [7:0] OP_STATUS    = 8'h00;
    localparam logic [7:0] OP_READ      = 8'h80;
    localparam logic [7:0] OP_WRITE     = 8'hC0;
    localparam logic [7:0] STATUS_MAGIC = 8'h5A;

    // Frame lengths in bytes
    localparam int unsigned STATUS_BYTES = 2;

    typedef enum logic [1:0] {
        CMD_STATUS = 2'b00,
        CMD_RSVD   = 2'b01,
        CMD_READ   = 2'b10,
        CMD_WRITE  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } msg_state_e;

    typedef enum logic [1:0] {
        BY_IDLE,
        BY_LOW,
        BY_HIGH
    } byte_state_e;

    // Register frames carry one header byte plus the data word
    function automatic int unsigned reg_frame_bytes(input int unsigned data_w);
        return 1 + data_w / 8;
    endfunction

    // First byte of a frame for a given command
    function automatic logic [7:0] header_byte(input cmd_op_e op, input logic [7:0] reg8);
        case (op)
            CMD_READ:  return OP_READ | reg8;
            CMD_WRITE: return OP_WRITE | reg8;
            default:   return OP_STATUS;
        endcase
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// Mode-3 single-byte shifter. A held start_i chains the next byte with no
// idle time; load_o pulses when tx_i is consumed, done_o when rx_o is valid.
module spi_master_byte
    import spi_msg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic       clk50MHz,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] tx_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       load_o,
    output logic       done_o,
    output logic [7:0] rx_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

    byte_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_sh_q;
    logic [7:0]       rx_sh_q;
    logic [7:0]       rx_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             load_q;
    logic             done_q;

    // Half-period sequencer: fall + MOSI update, then rise + MISO capture
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q <= BY_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                BY_IDLE: begin
                    if (start_i) begin
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_i[7];
                        tx_sh_q <= {tx_i[6:0], 1'b0};
                        bit_q   <= '0;
                        cnt_q   <= '0;
                        load_q  <= 1'b1;
                        state_q <= BY_LOW;
                    end
                end
                BY_LOW: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        sclk_q  <= 1'b1;
                        rx_sh_q <= {rx_sh_q[6:0], miso_i};
                        cnt_q   <= '0;
                        state_q <= BY_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BY_HIGH: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            done_q <= 1'b1;
                            rx_q   <= rx_sh_q;
                            if (start_i) begin
                                sclk_q  <= 1'b0;
                                mosi_q  <= tx_i[7];
                                tx_sh_q <= {tx_i[6:0], 1'b0};
                                bit_q   <= '0;
                                load_q  <= 1'b1;
                                state_q <= BY_LOW;
                            end else begin
                                state_q <= BY_IDLE;
                            end
                        end else begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= tx_sh_q[7];
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            bit_q   <= bit_q + 3'd1;
                            state_q <= BY_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= BY_IDLE;
            endcase
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign load_o = load_q;
    assign done_o = done_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/spi_msg_master.sv
// Mode-3 SPI master issuing complete spi_msg frames (status/read/write).
// Optional: define SPI_MSG_MASTER_STATUS_CHECK_EN to add the sticky status_err output.
module spi_msg_master
    import spi_msg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk50MHz,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [REG_W-1:0]  cmd_reg,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
    ,
    output logic              status_err
`endif
);

    localparam int unsigned CNT_W     = $clog2(CLK_DIV) + 1;
    localparam int unsigned REG_BYTES = reg_frame_bytes(DATA_W);
    localparam int unsigned BCNT_W    = $clog2(REG_BYTES + 1);

    msg_state_e        state_q;
    cmd_op_e           op_q;
    logic [REG_W-1:0]  reg_q;
    logic [DATA_W-1:0] wsh_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [7:0]        tx_q;
    logic [7:0]        last_rx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCNT_W-1:0] nbytes_q;
    logic [BCNT_W-1:0] idx_q;
    logic [BCNT_W-1:0] dcnt_q;
    logic              start_q;
    logic              ss_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              err_q;

    logic              load;
    logic              done;
    logic [7:0]        rx_byte;

    spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk50MHz (clk50MHz),
        .reset    (reset),
        .start_i  (start_q),
        .tx_i     (tx_q),
        .miso_i   (MISO),
        .sclk_o   (SCLK),
        .mosi_o   (MOSI),
        .load_o   (load),
        .done_o   (done),
        .rx_o     (rx_byte)
    );

    // Frame sequencer: owns SS, feeds bytes to the shifter, builds the response
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= CMD_STATUS;
            reg_q       <= '0;
            wsh_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            tx_q        <= '0;
            last_rx_q   <= '0;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            idx_q       <= '0;
            dcnt_q      <= '0;
            start_q     <= 1'b0;
            ss_q        <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        op_q    <= cmd_op_e'(cmd_op);
                        reg_q   <= cmd_reg;
                        wsh_q   <= (cmd_op_e'(cmd_op) == CMD_WRITE) ? cmd_wdata : '0;
                        idx_q   <= '0;
                        dcnt_q  <= '0;
                        nbytes_q <= (cmd_op_e'(cmd_op) == CMD_STATUS) ?
                                    BCNT_W'(STATUS_BYTES) : BCNT_W'(REG_BYTES);
                        if (cmd_op_e'(cmd_op) == CMD_RSVD) begin
                            // No SPI activity: respond on the next cycle
                            cnt_q   <= CNT_W'(CLK_DIV - 1);
                            state_q <= ST_HOLD;
                        end else begin
                            cnt_q   <= '0;
                            ss_q    <= 1'b0;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        start_q <= 1'b1;
                        tx_q    <= header_byte(op_q, 8'(reg_q));
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    // Stage the following byte as soon as the shifter takes one
                    if (load) begin
                        if (idx_q == nbytes_q - BCNT_W'(1)) begin
                            start_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + BCNT_W'(1);
                            tx_q  <= wsh_q[DATA_W-1 -: 8];
                            wsh_q <= wsh_q << 8;
                        end
                    end
                    if (done) begin
                        data_q    <= {data_q[DATA_W-9:0], rx_byte};
                        last_rx_q <= rx_byte;
                        if (dcnt_q == nbytes_q - BCNT_W'(1)) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_HOLD;
                        end else begin
                            dcnt_q <= dcnt_q + BCNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        ss_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        case (op_q)
                            CMD_STATUS: rsp_data_q <= DATA_W'(last_rx_q);
                            CMD_READ:   rsp_data_q <= data_q;
                            default:    rsp_data_q <= '0;
                        endcase
                        if (op_q == CMD_STATUS && last_rx_q != STATUS_MAGIC) begin
                            err_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS        = ss_q;

`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
    assign status_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_spi_msg_master.sv
// Directed bench for spi_msg_master with a mode-3 slave model and line monitors.
module tb_spi_msg_master;

    logic        clk50MHz = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_reg = 4'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;
    logic        SS;
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
    logic        status_err;
`endif

    spi_msg_master dut (
        .clk50MHz  (clk50MHz),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .SS        (SS)
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
        ,
        .status_err(status_err)
`endif
    );

    initial forever #10 clk50MHz = ~clk50MHz;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rg;
        logic [31:0] wdata;
        logic [39:0] resp;
        int          nbits;
        logic [39:0] exp_mosi;
        int          exp_lat;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs [7];

    int checks = 0;
    int errors = 0;

    // slave model / monitor state (written only by the monitor)
    logic [39:0] resp_bits = 40'h0;
    int          nbits_cur = 0;
    logic        mon_en = 1'b0;
    logic        ss_p = 1'b1, sclk_p = 1'b1, mosi_p = 1'b0;
    logic [39:0] mosi_cap = 40'h0;
    int bitn = 0, rises = 0, ss_falls = 0, rsp_pulses = 0, accepts = 0;
    int mosi_viol = 0, ready_viol = 0, gap = 0, min_gap = 1000000;
    logic seen_low = 1'b0;

    // Mode-3 slave: MISO changes after SCLK falls, MOSI captured at SCLK rise
    always @(negedge clk50MHz) begin
        ss_p   <= SS;
        sclk_p <= SCLK;
        mosi_p <= MOSI;
        if (ss_p === 1'b1 && SS === 1'b0) begin
            bitn     <= 0;
            ss_falls <= ss_falls + 1;
        end
        if (SS === 1'b0 && sclk_p === 1'b1 && SCLK === 1'b0 && bitn < nbits_cur)
            MISO <= resp_bits[nbits_cur-1-bitn];
        if (SS === 1'b0 && sclk_p === 1'b0 && SCLK === 1'b1) begin
            mosi_cap <= {mosi_cap[38:0], MOSI};
            bitn     <= bitn + 1;
            rises    <= rises + 1;
        end
        if (rsp_valid === 1'b1) rsp_pulses <= rsp_pulses + 1;
        if (cmd_valid && cmd_ready === 1'b1 && !reset) accepts <= accepts + 1;
        if (mon_en) begin
            if (MOSI !== mosi_p && !(sclk_p === 1'b1 && SCLK === 1'b0))
                mosi_viol <= mosi_viol + 1;
            if (cmd_ready === 1'b1 && SS === 1'b0) ready_viol <= ready_viol + 1;
            if (SS === 1'b1) begin
                gap <= gap + 1;
            end else begin
                if (ss_p === 1'b1 && seen_low && gap < min_gap) min_gap <= gap;
                gap      <= 0;
                seen_low <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk50MHz);
        #1;
    endtask

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk("ready_timeout", 40'(cmd_ready), 40'd1);
    endtask

    // Issue one table vector and check the whole transaction
    task automatic run_vec(input int i);
        int lat = 0;
        int r0, f0;
        logic [39:0] m;
        resp_bits = vecs[i].resp;
        nbits_cur = vecs[i].nbits;
        wait_ready();
        r0 = rises;
        f0 = ss_falls;
        cmd_op    = vecs[i].op;
        cmd_reg   = vecs[i].rg;
        cmd_wdata = vecs[i].wdata;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 3000) begin
            step();
            lat++;
        end
        chk($sformatf("v%0d_latency", i), 40'(lat), 40'(vecs[i].exp_lat));
        chk($sformatf("v%0d_rsp_data", i), 40'(rsp_data), 40'(vecs[i].exp_rsp));
        chk($sformatf("v%0d_sclk_rises", i), 40'(rises - r0), 40'(vecs[i].nbits));
        chk($sformatf("v%0d_ss_frames", i), 40'(ss_falls - f0), 40'(vecs[i].nbits > 0 ? 1 : 0));
        if (vecs[i].nbits > 0) begin
            m = '1;
            if (vecs[i].nbits < 40) m = (40'd1 << vecs[i].nbits) - 40'd1;
            chk($sformatf("v%0d_mosi", i), mosi_cap & m, vecs[i].exp_mosi);
        end
        step();
        chk($sformatf("v%0d_rsp_pulse_width", i), 40'(rsp_valid), 40'd0);
        chk($sformatf("v%0d_rsp_hold", i), 40'(rsp_data), 40'(vecs[i].exp_rsp));
    endtask

    initial begin
        int p0, a0, r0, n;

        vecs[0] = '{2'b00, 4'h0, 32'h0,        40'h000000005A, 16, 40'h0000000000, 205, 32'h0000005A};
        vecs[1] = '{2'b11, 4'h0, 32'h76543210, 40'h0000000000, 40, 40'hC076543210, 493, 32'h00000000};
        vecs[2] = '{2'b10, 4'h4, 32'h0,        40'h00DEADBEEF, 40, 40'h8400000000, 493, 32'hDEADBEEF};
        vecs[3] = '{2'b11, 4'hF, 32'hA5A50F0F, 40'hFFFFFFFFFF, 40, 40'hCFA5A50F0F, 493, 32'h00000000};
        vecs[4] = '{2'b10, 4'hA, 32'hFFFFFFFF, 40'hFF12345678, 40, 40'h8A00000000, 493, 32'h12345678};
        vecs[5] = '{2'b00, 4'h7, 32'h1234,     40'h000000FFC3, 16, 40'h0000000000, 205, 32'h000000C3};
        vecs[6] = '{2'b01, 4'h3, 32'hCAFEF00D, 40'h0000000000, 0,  40'h0000000000, 1,   32'h00000000};

        // Reset state
        repeat (3) step();
        chk("rst_ss", 40'(SS), 40'd1);
        chk("rst_sclk", 40'(SCLK), 40'd1);
        chk("rst_mosi", 40'(MOSI), 40'd0);
        chk("rst_ready", 40'(cmd_ready), 40'd0);
        chk("rst_rsp_valid", 40'(rsp_valid), 40'd0);
        chk("rst_rsp_data", 40'(rsp_data), 40'd0);
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
        chk("rst_status_err", 40'(status_err), 40'd0);
`endif
        reset = 1'b0;
        step();
        chk("ready_after_reset", 40'(cmd_ready), 40'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
        chk("status_err_set", 40'(status_err), 40'd1);
`endif

        // cmd_valid held through three back-to-back status reads
        resp_bits = 40'h000000005A;
        nbits_cur = 16;
        wait_ready();
        p0 = rsp_pulses;
        a0 = accepts;
        cmd_op = 2'b00;
        cmd_valid = 1'b1;
        n = 0;
        while (rsp_pulses - p0 < 3 && n < 5000) begin
            step();
            n++;
        end
        cmd_valid = 1'b0;
        repeat (20) step();
        chk("held_rsp_count", 40'(rsp_pulses - p0), 40'd3);
        chk("held_accepts", 40'(accepts - a0), 40'd3);
        chk("ready_during_frame", 40'(ready_viol), 40'd0);
        chk("min_ss_gap_ok", 40'(min_gap >= 6 ? 1 : 0), 40'd1);
        chk("mosi_only_on_fall", 40'(mosi_viol), 40'd0);
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
        chk("status_err_sticky", 40'(status_err), 40'd1);
`endif

        // Reset during bit 13 of a write frame
        resp_bits = 40'h0;
        nbits_cur = 40;
        wait_ready();
        r0 = rises;
        cmd_op = 2'b11;
        cmd_reg = 4'h3;
        cmd_wdata = 32'h13579BDF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!(rises - r0 >= 13 && SCLK === 1'b0) && n < 3000) begin
            step();
            n++;
        end
        chk("reached_bit13", 40'(rises - r0), 40'd13);
        mon_en = 1'b0;
        reset = 1'b1;
        step();
        chk("abort_ss", 40'(SS), 40'd1);
        chk("abort_sclk", 40'(SCLK), 40'd1);
        chk("abort_rsp_valid", 40'(rsp_valid), 40'd0);
        chk("abort_ready", 40'(cmd_ready), 40'd0);
        reset = 1'b0;
        p0 = rsp_pulses;
        step();
        mon_en = 1'b1;
        chk("abort_ready_next", 40'(cmd_ready), 40'd1);
        repeat (600) step();
        chk("abort_no_rsp", 40'(rsp_pulses - p0), 40'd0);
`ifdef SPI_MSG_MASTER_STATUS_CHECK_EN
        chk("status_err_cleared", 40'(status_err), 40'd0);
`endif
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
